// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus between the CPU memory controller (master) and the
// memory-side responder (slave): address, direction, write data, read data
// and the backpressure flag the controller samples before each access.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a,
        output mem_wr,
        output mem_dout,
        input  mem_din,
        input  io_buffer_full
    );

    modport slave (
        input  mem_a,
        input  mem_wr,
        input  mem_dout,
        output mem_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the CPU memory controller.
// Serves single-byte RAM reads/writes, decodes the IO window at
// addr[17:16]==2'b11, queues outgoing UART bytes in a TX FIFO and drives
// the io_buffer_full backpressure flag.
// Optional feature macro IO_RX_EN: adds a UART RX FIFO read through IO
// address 0x30000. With it undefined that address reads as 0.
module mem_io_responder #(
    parameter int ADDR_W      = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    mem_io_responder_if.slave   bus,
    output logic                uart_tx_valid,
    output logic [7:0]          uart_tx_data,
    input  logic                uart_tx_ready,
    output logic                tx_overflow,
    output logic                sim_halt
`ifdef IO_RX_EN
    ,
    input  logic                uart_rx_valid,
    input  logic [7:0]          uart_rx_data,
    output logic                uart_rx_ready
`endif
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;

    // ---------------- bus decode ----------------
    logic io_sel;
    logic ram_we;
    logic ram_re;
    logic io_re;
    logic tx_wr_req;
    logic halt_req;
    logic unused_addr_bits;

    assign io_sel    = (bus.mem_a[17:16] == 2'b11);
    assign ram_we    = rdy_in &&  bus.mem_wr && !io_sel;
    assign ram_re    = rdy_in && !bus.mem_wr && !io_sel;
    assign io_re     = rdy_in && !bus.mem_wr &&  io_sel;
    assign tx_wr_req = rdy_in &&  bus.mem_wr && (bus.mem_a[17:0] == IO_UART_ADDR);
    assign halt_req  = rdy_in &&  bus.mem_wr && (bus.mem_a[17:0] == IO_CTRL_ADDR);

    // Upper address bits are outside the decoded map.
    assign unused_addr_bits = ^bus.mem_a[31:18];

    // ---------------- RAM ----------------
    logic [7:0] ram [0:(2**ADDR_W)-1];

    // RAM write port.
    // NOTE: storage arrays carry no reset so they map onto block RAM; only control state is reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[bus.mem_a[ADDR_W-1:0]] <= bus.mem_dout;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] tx_wr_ptr;
    logic [PTR_W-1:0] tx_rd_ptr;
    logic [PTR_W-1:0] tx_count;
    logic [PTR_W-1:0] tx_count_nxt;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push;
    logic             tx_pop;

    assign tx_full  = (tx_wr_ptr[PTR_W-1] != tx_rd_ptr[PTR_W-1]) &&
                      (tx_wr_ptr[IDX_W-1:0] == tx_rd_ptr[IDX_W-1:0]);
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_count = tx_wr_ptr - tx_rd_ptr;

    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_mem[tx_rd_ptr[IDX_W-1:0]];
    assign tx_pop        = uart_tx_valid && uart_tx_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign tx_push       = tx_wr_req && (!tx_full || tx_pop);

    // Occupancy after this cycle's push/pop, used for the registered backpressure flag.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_count_nxt = tx_count;
        if (tx_push && !tx_pop) begin
            tx_count_nxt = tx_count + PTR_W'(1);
        end else if (!tx_push && tx_pop) begin
            tx_count_nxt = tx_count - PTR_W'(1);
        end
    end

    // TX FIFO data storage.
    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr[IDX_W-1:0]] <= bus.mem_dout;
        end
    end

    // TX FIFO pointers, backpressure flag, sticky overflow and halt pulse.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wr_ptr          <= '0;
            tx_rd_ptr          <= '0;
            bus.io_buffer_full <= 1'b0;
            tx_overflow        <= 1'b0;
            sim_halt           <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            end
            bus.io_buffer_full <= (tx_count_nxt >= PTR_W'(FIFO_DEPTH - FULL_MARGIN));
            if (tx_wr_req && tx_full && !tx_pop) begin
                tx_overflow <= 1'b1;
            end
            sim_halt <= halt_req;
        end
    end

    // ---------------- optional RX FIFO ----------------
    logic rx_rd_req;
    assign rx_rd_req = io_re && (bus.mem_a[17:0] == IO_UART_ADDR);

`ifdef IO_RX_EN
    logic [7:0]       rx_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] rx_wr_ptr;
    logic [PTR_W-1:0] rx_rd_ptr;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_pop;
    logic [7:0]       rx_head;

    assign rx_full       = (rx_wr_ptr[PTR_W-1] != rx_rd_ptr[PTR_W-1]) &&
                           (rx_wr_ptr[IDX_W-1:0] == rx_rd_ptr[IDX_W-1:0]);
    assign rx_empty      = (rx_wr_ptr == rx_rd_ptr);
    assign uart_rx_ready = !rx_full;
    assign rx_push       = uart_rx_valid && uart_rx_ready;
    assign rx_pop        = rx_rd_req && !rx_empty;
    assign rx_head       = rx_mem[rx_rd_ptr[IDX_W-1:0]];

    // RX FIFO data storage.
    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr[IDX_W-1:0]] <= uart_rx_data;
        end
    end

    // RX FIFO pointers; a bus read of the UART address consumes the head.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            end
        end
    end
`endif

    // ---------------- read data ----------------
    logic [7:0] io_rd_data;

    // IO register read mux; unmapped IO addresses read as zero.
    always_comb begin
        io_rd_data = 8'h00;
        if (bus.mem_a[17:0] == IO_CTRL_ADDR) begin
            io_rd_data = {7'b0, bus.io_buffer_full};
        end
`ifdef IO_RX_EN
        else if (rx_rd_req && !rx_empty) begin
            io_rd_data = rx_head;
        end
`endif
    end

    // Registered read data: one-cycle latency, holds on writes and while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bus.mem_din <= 8'h00;
        end else if (ram_re) begin
            bus.mem_din <= ram[bus.mem_a[ADDR_W-1:0]];
        end else if (io_re) begin
            bus.mem_din <= io_rd_data;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM read/write,
// rdy_in freeze, TX FIFO fill/overflow/wrap, sim_halt pulse, async reset
// mid-drain and (with IO_RX_EN) RX reads.
module tb_mem_io_responder;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic uart_tx_valid;
    logic [7:0] uart_tx_data;
    logic uart_tx_ready;
    logic tx_overflow;
    logic sim_halt;
`ifdef IO_RX_EN
    logic uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic uart_rx_ready;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .bus           (bus),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .tx_overflow   (tx_overflow),
        .sim_halt      (sim_halt)
`ifdef IO_RX_EN
        ,
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Park the bus on a harmless unmapped IO read.
    task automatic bus_idle();
        bus.mem_wr   = 1'b0;
        bus.mem_a    = 32'h0003_0008;
        bus.mem_dout = 8'h00;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_wr   = 1'b1;
        bus.mem_dout = d;
        step();
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a);
        bus.mem_a  = a;
        bus.mem_wr = 1'b0;
        step();
        bus_idle();
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        uart_tx_ready = 1'b0;
        bus_idle();
`ifdef IO_RX_EN
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
`endif
        #3;
        check("rst_mem_din",   32'(bus.mem_din), 32'h0);
        check("rst_ibf",       32'(bus.io_buffer_full), 32'h0);
        check("rst_tx_valid",  32'(uart_tx_valid), 32'h0);
        check("rst_overflow",  32'(tx_overflow), 32'h0);
        check("rst_sim_halt",  32'(sim_halt), 32'h0);
        #10;
        rst_in = 1'b1;
        step();

        // RAM write then read, back-to-back reads.
        bus_write(32'h0000_0010, 8'hA5);
        bus_write(32'h0000_0011, 8'h5A);
        bus_read(32'h0000_0010);
        check("ram_rd_10", 32'(bus.mem_din), 32'hA5);
        bus_read(32'h0000_0011);
        check("ram_rd_11", 32'(bus.mem_din), 32'h5A);

        // Writes leave mem_din alone.
        bus_write(32'h0000_0020, 8'h11);
        check("din_hold_wr", 32'(bus.mem_din), 32'h5A);

        // rdy_in low freezes the bus side.
        rdy_in = 1'b0;
        bus_read(32'h0000_0010);
        check("din_hold_rdy", 32'(bus.mem_din), 32'h5A);
        bus_write(32'h0000_0020, 8'h3C);
        rdy_in = 1'b1;
        bus_read(32'h0000_0020);
        check("ram_frozen_wr", 32'(bus.mem_din), 32'h11);

        // Unmapped IO and (non-RX) UART address read as zero.
        bus_read(32'h0003_0008);
        check("io_unmapped_rd", 32'(bus.mem_din), 32'h0);
`ifndef IO_RX_EN
        bus_read(32'h0000_0010);
        bus_read(32'h0003_0000);
        check("io_uart_rd_zero", 32'(bus.mem_din), 32'h0);
`endif

        // Fill TX FIFO with sink stalled; watch backpressure threshold.
        check("tx_empty_pre", 32'(uart_tx_valid), 32'h0);
        bus_write(32'h0003_0000, 8'h01);
        check("tx_valid_rise", 32'(uart_tx_valid), 32'h1);
        for (int i = 2; i <= 5; i++) bus_write(32'h0003_0000, 8'(i));
        check("ibf_at_5", 32'(bus.io_buffer_full), 32'h0);
        bus_write(32'h0003_0000, 8'h06);
        check("ibf_at_6", 32'(bus.io_buffer_full), 32'h1);
        bus_write(32'h0003_0000, 8'h07);
        bus_write(32'h0003_0000, 8'h08);
        check("ovf_at_8", 32'(tx_overflow), 32'h0);
        bus_write(32'h0003_0000, 8'h09);
        check("ovf_at_9", 32'(tx_overflow), 32'h1);
        check("head_after_ovf", 32'(uart_tx_data), 32'h01);
        bus_read(32'h0003_0004);
        check("io_status_rd", 32'(bus.mem_din), 32'h1);

        // Full FIFO: pop and push in the same cycle.
        uart_tx_ready = 1'b1;
        bus.mem_a     = 32'h0003_0000;
        bus.mem_wr    = 1'b1;
        bus.mem_dout  = 8'h0A;
        step();
        uart_tx_ready = 1'b0;
        bus_idle();
        check("ibf_full_pushpop", 32'(bus.io_buffer_full), 32'h1);

        // Drain: order preserved across pointer wrap, dropped 0x09 absent.
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(uart_tx_valid), 32'h1);
            check($sformatf("drain_data_%0d", i), 32'(uart_tx_data), 32'(drain_exp[i]));
            step();
        end
        check("drain_empty", 32'(uart_tx_valid), 32'h0);
        check("drain_ibf", 32'(bus.io_buffer_full), 32'h0);
        check("ovf_sticky", 32'(tx_overflow), 32'h1);

        // sim_halt pulse, no FIFO effect.
        bus_write(32'h0003_0004, 8'hFF);
        check("halt_pulse", 32'(sim_halt), 32'h1);
        check("halt_no_push", 32'(uart_tx_valid), 32'h0);
        step();
        check("halt_clear", 32'(sim_halt), 32'h0);

        // Async reset mid-drain with a read in flight.
        uart_tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'h11);
        bus_write(32'h0003_0000, 8'h22);
        bus_write(32'h0003_0000, 8'h33);
        uart_tx_ready = 1'b1;
        step();
        check("middrain_head", 32'(uart_tx_data), 32'h22);
        bus.mem_a  = 32'h0000_0010;
        bus.mem_wr = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("arst_mem_din", 32'(bus.mem_din), 32'h0);
        check("arst_overflow", 32'(tx_overflow), 32'h0);
        #1;
        rst_in = 1'b1;
        bus_idle();
        step();
        check("post_rst_empty", 32'(uart_tx_valid), 32'h0);
        check("post_rst_ibf", 32'(bus.io_buffer_full), 32'h0);
        uart_tx_ready = 1'b0;

`ifdef IO_RX_EN
        // RX: two bytes in, three reads out.
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h41;
        step();
        uart_rx_data  = 8'h42;
        step();
        uart_rx_valid = 1'b0;
        bus_read(32'h0003_0000);
        check("rx_rd_0", 32'(bus.mem_din), 32'h41);
        bus_read(32'h0003_0000);
        check("rx_rd_1", 32'(bus.mem_din), 32'h42);
        bus_read(32'h0000_0010);
        bus_read(32'h0003_0000);
        check("rx_rd_empty", 32'(bus.mem_din), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
